// File: rtl/estimador_demux_pkg.sv
// Shared types and constants for the estimator 1:3 result demux.
// Contents: channel count, select width/type, invalid select code, default data width.
package estimador_demux_pkg;

    localparam int unsigned NUM_CH         = 3;
    localparam int unsigned SEL_WIDTH      = 2;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned DROP_CNT_WIDTH = 16;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    // Select code that addresses no channel; such words are dropped.
    localparam sel_t SEL_INVALID = 2'd3;

endpackage : estimador_demux_pkg

// File: rtl/estimador_func_demux_32_1_3_if.sv
// Valid/ready bus bundle for the estimator 1:3 demux.
// Signals:
//   din/din_sel/din_valid -> producer to demux, din_ready <- demux
//   doutK/doutK_valid     -> demux to consumer K, doutK_ready <- consumer K
// Modports: master = producer/consumer side (testbench), slave = demux.
interface estimador_func_demux_32_1_3_if
    import estimador_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = estimador_demux_pkg::DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] din;
    sel_t                  din_sel;
    logic                  din_valid;
    logic                  din_ready;

    logic [DATA_WIDTH-1:0] dout0;
    logic [DATA_WIDTH-1:0] dout1;
    logic [DATA_WIDTH-1:0] dout2;
    logic                  dout0_valid;
    logic                  dout1_valid;
    logic                  dout2_valid;
    logic                  dout0_ready;
    logic                  dout1_ready;
    logic                  dout2_ready;

    modport master (
        output din, din_sel, din_valid,
        input  din_ready,
        input  dout0, dout1, dout2,
        input  dout0_valid, dout1_valid, dout2_valid,
        output dout0_ready, dout1_ready, dout2_ready
    );

    modport slave (
        input  din, din_sel, din_valid,
        output din_ready,
        output dout0, dout1, dout2,
        output dout0_valid, dout1_valid, dout2_valid,
        input  dout0_ready, dout1_ready, dout2_ready
    );

endinterface : estimador_func_demux_32_1_3_if

// File: rtl/estimador_demux_fifo.sv
// Single-channel synchronous FIFO with a registered head output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_data (ignored when full)
//   i_pop       : drop head entry (ignored when empty)
//   i_data      : write data
//   o_head      : current head entry; holds its last value while empty
//   o_full_c    : FIFO holds DEPTH entries (decoded from registered count)
//   o_empty_c   : FIFO holds no entries (decoded from registered count)
// DEPTH must be a power of two and at least 2.
module estimador_demux_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full_c,
    output logic                  o_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_head;

    logic                  w_push;
    logic                  w_pop;
    logic [PTR_W-1:0]      w_rd_nxt;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop  && !o_empty_c;
    // Power-of-two depth: natural pointer overflow is the modulo wrap.
    assign w_rd_nxt  = r_rd_ptr + PTR_W'(1);
    assign o_head    = r_head;

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Head tracks the oldest entry; when the FIFO drains it keeps the
            // last popped word instead of exposing a stale memory slot.
            if (w_pop) begin
                if (r_count >= CNT_W'(2)) begin
                    r_head <= r_mem[w_rd_nxt];
                end else if (w_push) begin
                    r_head <= i_data;
                end
            end else if (w_push && o_empty_c) begin
                r_head <= i_data;
            end
        end
    end

endmodule : estimador_demux_fifo

// File: rtl/estimador_func_demux_32_1_3.sv
// Estimator 1:3 result demux: routes a tagged word stream to three buffered
// valid/ready output channels, one FIFO per channel so a stalled consumer
// only blocks words addressed to it.
// Ports:
//   ap_clk    : clock, rising edge
//   ap_rst_n  : asynchronous active-low reset
//   bus       : slave side of estimador_func_demux_32_1_3_if (din/din_sel/
//               din_valid/din_ready, doutK/doutK_valid/doutK_ready)
//   err_sel   : sticky, set when a word with din_sel=3 is accepted
//   drop_cnt  : (only with ESTIMADOR_DEMUX_DROP_CNT_EN) saturating count of
//               accepted din_sel=3 words
// Optional feature macro: ESTIMADOR_DEMUX_DROP_CNT_EN.
module estimador_func_demux_32_1_3
    import estimador_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = estimador_demux_pkg::DATA_WIDTH,
    parameter int unsigned SEL_WIDTH  = estimador_demux_pkg::SEL_WIDTH,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    estimador_func_demux_32_1_3_if.slave  bus,
    output logic                          err_sel
`ifdef ESTIMADOR_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0]     drop_cnt
`endif
);

    logic [SEL_WIDTH-1:0]  w_sel;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_push;
    logic [NUM_CH-1:0]     w_pop;
    logic [NUM_CH-1:0]     w_out_ready;
    logic [DATA_WIDTH-1:0] w_head [NUM_CH];
    logic                  w_ready_c;
    logic                  w_drop;
    logic                  r_err_sel;

    assign w_sel       = SEL_WIDTH'(bus.din_sel);
    assign w_out_ready = {bus.dout2_ready, bus.dout1_ready, bus.dout0_ready};

    // Select decode and ready generation; ready never looks at din_valid and
    // is forced low while reset is held.
    always_comb begin
        w_ready_c = 1'b0;
        w_push    = '0;
        w_pop     = '0;
        if (w_sel == SEL_WIDTH'(SEL_INVALID)) begin
            w_ready_c = 1'b1;
        end
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (w_sel == SEL_WIDTH'(k)) begin
                w_ready_c = !w_full[k];
            end
        end
        w_ready_c = w_ready_c && ap_rst_n;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            w_push[k] = bus.din_valid && w_ready_c && (w_sel == SEL_WIDTH'(k));
            w_pop[k]  = w_out_ready[k] && !w_empty[k];
        end
    end

    assign w_drop = bus.din_valid && w_ready_c && (w_sel == SEL_WIDTH'(SEL_INVALID));

    // One independent FIFO per output channel.
    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
        estimador_demux_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (ap_clk),
            .rst_n     (ap_rst_n),
            .i_push    (w_push[k]),
            .i_pop     (w_pop[k]),
            .i_data    (bus.din),
            .o_head    (w_head[k]),
            .o_full_c  (w_full[k]),
            .o_empty_c (w_empty[k])
        );
    end

    assign bus.din_ready   = w_ready_c;
    assign bus.dout0       = w_head[0];
    assign bus.dout1       = w_head[1];
    assign bus.dout2       = w_head[2];
    assign bus.dout0_valid = !w_empty[0];
    assign bus.dout1_valid = !w_empty[1];
    assign bus.dout2_valid = !w_empty[2];

    // Sticky invalid-select flag; only reset clears it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_err_sel <= 1'b0;
        end else if (w_drop) begin
            r_err_sel <= 1'b1;
        end
    end

    assign err_sel = r_err_sel;

`ifdef ESTIMADOR_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    // Saturating count of dropped words.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule : estimador_func_demux_32_1_3

// File: tb/tb_estimador_func_demux_32_1_3.sv
// Scoreboard bench for the estimator 1:3 demux: stimulus pushes expected words
// per channel, a negedge monitor compares every presented head entry.
module tb_estimador_func_demux_32_1_3;
    import estimador_demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic err_sel;
`ifdef ESTIMADOR_DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    estimador_func_demux_32_1_3_if #(.DATA_WIDTH(32)) bus ();

    estimador_func_demux_32_1_3 #(
        .DATA_WIDTH (32),
        .SEL_WIDTH  (2),
        .DEPTH      (2)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.slave),
        .err_sel  (err_sel)
`ifdef ESTIMADOR_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [3][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic mon_chk(input int k, input logic v, input logic r, input logic [31:0] d);
        if (v) begin
            if (exp_q[k].size() == 0) begin
                total++;
                bad++;
                $display("FAIL ch%0d_unexpected: got %h expected nothing", k, d);
            end else begin
                check($sformatf("ch%0d_head", k), d, exp_q[k][0]);
                if (r) void'(exp_q[k].pop_front());
            end
        end
    endtask

    // Monitor: head must match oldest expected word; a pop retires it.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_chk(0, bus.dout0_valid, bus.dout0_ready, bus.dout0);
            mon_chk(1, bus.dout1_valid, bus.dout1_ready, bus.dout1);
            mon_chk(2, bus.dout2_valid, bus.dout2_ready, bus.dout2);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input sel_t s);
        int   n  = 0;
        logic ok = 1'b0;
        bus.din       = d;
        bus.din_sel   = s;
        bus.din_valid = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (bus.din_ready) begin
                ok = 1'b1;
                if (s != SEL_INVALID) exp_q[int'(s)].push_back(d);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.din_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %h sel %0d not accepted in %0d cycles", d, s, n);
        end
    endtask

    task automatic set_ready(input logic r0, input logic r1, input logic r2);
        bus.dout0_ready = r0;
        bus.dout1_ready = r1;
        bus.dout2_ready = r2;
    endtask

    task automatic drain();
        set_ready(1'b1, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        set_ready(1'b0, 1'b0, 1'b0);
        check("q0_drained", 32'(exp_q[0].size()), 32'd0);
        check("q1_drained", 32'(exp_q[1].size()), 32'd0);
        check("q2_drained", 32'(exp_q[2].size()), 32'd0);
        check_bit("drain_v0", bus.dout0_valid, 1'b0);
        check_bit("drain_v1", bus.dout1_valid, 1'b0);
        check_bit("drain_v2", bus.dout2_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.din       = '0;
        bus.din_sel   = 2'd0;
        bus.din_valid = 1'b1;
        set_ready(1'b0, 1'b0, 1'b0);

        // Reset state, with din_valid high to show ready stays low.
        #12;
        check_bit("rst_ready", bus.din_ready, 1'b0);
        check_bit("rst_v0", bus.dout0_valid, 1'b0);
        check_bit("rst_v1", bus.dout1_valid, 1'b0);
        check_bit("rst_v2", bus.dout2_valid, 1'b0);
        check("rst_d0", bus.dout0, 32'h0);
        check("rst_d2", bus.dout2, 32'h0);
        check_bit("rst_err", err_sel, 1'b0);
        bus.din_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word to channel 0, visible right after the accepting edge.
        send(32'hA0000001, 2'd0);
        check_bit("t1_v0", bus.dout0_valid, 1'b1);
        check("t1_d0", bus.dout0, 32'hA0000001);
        check_bit("t1_v1", bus.dout1_valid, 1'b0);
        check_bit("t1_v2", bus.dout2_valid, 1'b0);
        drain();

        // Channel 1 fills at two entries; third word waits for a pop.
        send(32'h11110001, 2'd1);
        send(32'h11110002, 2'd1);
        bus.din       = 32'h11110003;
        bus.din_sel   = 2'd1;
        bus.din_valid = 1'b1;
        @(negedge clk);
        check_bit("t2_full_stall", bus.din_ready, 1'b0);
        @(posedge clk);
        #1 bus.dout1_ready = 1'b1;
        @(negedge clk);
        check_bit("t2_no_pop_through", bus.din_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("t2_accept_after_pop", bus.din_ready, 1'b1);
        exp_q[1].push_back(32'h11110003);
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
        drain();

        // Full stalled channel 2 does not block channel 0.
        send(32'h22220001, 2'd2);
        send(32'h22220002, 2'd2);
        bus.din       = 32'h00000C0D;
        bus.din_sel   = 2'd0;
        bus.din_valid = 1'b1;
        @(negedge clk);
        check_bit("t3_no_cross_block", bus.din_ready, 1'b1);
        exp_q[0].push_back(32'h00000C0D);
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
        check_bit("t3_v0", bus.dout0_valid, 1'b1);
        check("t3_d2_head", bus.dout2, 32'h22220001);
        drain();

        // Invalid select: accepted, discarded, sticky flag.
        bus.din       = 32'hDEADBEEF;
        bus.din_sel   = 2'd3;
        bus.din_valid = 1'b1;
        @(negedge clk);
        check_bit("t4_sel3_ready", bus.din_ready, 1'b1);
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
        check_bit("t4_err", err_sel, 1'b1);
        check_bit("t4_v0", bus.dout0_valid, 1'b0);
        check_bit("t4_v1", bus.dout1_valid, 1'b0);
        check_bit("t4_v2", bus.dout2_valid, 1'b0);
`ifdef ESTIMADOR_DEMUX_DROP_CNT_EN
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_bit("t4_err_sticky", err_sel, 1'b1);

        // Push and pop together on a one-entry channel 0.
        send(32'h0000AAAA, 2'd0);
        bus.din         = 32'h0000BBBB;
        bus.din_sel     = 2'd0;
        bus.din_valid   = 1'b1;
        bus.dout0_ready = 1'b1;
        @(negedge clk);
        check_bit("t5_ready", bus.din_ready, 1'b1);
        exp_q[0].push_back(32'h0000BBBB);
        @(posedge clk);
        #1;
        bus.din_valid   = 1'b0;
        bus.dout0_ready = 1'b0;
        check_bit("t5_v0", bus.dout0_valid, 1'b1);
        check("t5_new_head", bus.dout0, 32'h0000BBBB);
        bus.dout0_ready = 1'b1;
        @(posedge clk);
        #1 bus.dout0_ready = 1'b0;
        check_bit("t5_count_one", bus.dout0_valid, 1'b0);
        check("t5_hold_last", bus.dout0, 32'h0000BBBB);

        // Reset in the middle of a cycle with channel 0 full.
        send(32'h0000CC01, 2'd0);
        send(32'h0000CC02, 2'd0);
        bus.din       = 32'h0000CC03;
        bus.din_sel   = 2'd0;
        bus.din_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("t6_rst_v0", bus.dout0_valid, 1'b0);
        check_bit("t6_rst_ready", bus.din_ready, 1'b0);
        check("t6_rst_d0", bus.dout0, 32'h0);
        exp_q[0].delete();
        bus.din_valid = 1'b0;
        #10 rst_n = 1'b1;
        #1;
        check_bit("t6_post_v0", bus.dout0_valid, 1'b0);
        check_bit("t6_post_err", err_sel, 1'b0);
`ifdef ESTIMADOR_DEMUX_DROP_CNT_EN
        check("t6_post_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        send(32'h0000DD01, 2'd0);
        check("t6_after_rst_head", bus.dout0, 32'h0000DD01);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_estimador_func_demux_32_1_3

// File: doc/estimador_func_demux_32_1_3.md
Name: estimador_func_demux_32_1_3

Overview:
Inverse of the estimator's 3:1 select mux. Takes one 32-bit word stream tagged with a 2-bit channel select and routes each word to one of three buffered output channels (din0/din1/din2 side of the datapath). Used to scatter serialized estimator results back into three parallel state-vector consumers. Both sides use valid/ready handshakes. Each channel has its own small FIFO so a stalled consumer does not block the other channels.

Parameters:
DATA_WIDTH, 32, width of the data word on input and on every output channel
SEL_WIDTH, 2, width of the channel select
DEPTH, 2, entries per channel FIFO; must be a power of two and at least 2

Ports:
ap_clk  input  1  single clock; all logic is rising-edge
ap_rst_n  input  1  asynchronous, active-low reset
din  input  DATA_WIDTH  input word
din_sel  input  SEL_WIDTH  destination channel: 0, 1 or 2; 3 is invalid
din_valid  input  1  input word and din_sel are valid
din_ready  output  1  block accepts the word this cycle
dout0 / dout1 / dout2  output  DATA_WIDTH each  head entry of the channel FIFO
dout0_valid / dout1_valid / dout2_valid  output  1 each  channel FIFO is not empty
dout0_ready / dout1_ready / dout2_ready  input  1 each  consumer pops the head entry
err_sel  output  1  sticky flag: a word with din_sel=3 was accepted

Behaviour:
- Reset (ap_rst_n=0, takes effect immediately):
  - All FIFOs empty; dout*_valid=0; dout*=0; err_sel=0.
  - din_ready=0 while reset is asserted.
- Input transfer:
  - A transfer occurs on a rising edge when din_valid && din_ready.
  - din_ready is combinational from din_sel and the registered FIFO counts. It never depends on din_valid.
  - din_sel in 0..2: din_ready = !full[din_sel].
  - din_sel = 3: din_ready = 1. The word is discarded and err_sel is set to 1. err_sel clears only on reset.
- Latency: a word accepted at edge N is visible on dout<k> with dout<k>_valid=1 after edge N. That is one cycle when the FIFO was empty; otherwise it waits behind older entries.
- Output transfer: the head entry is popped on an edge where dout<k>_valid && dout<k>_ready. dout<k> always shows the current head entry.
- Per-channel ordering is strict FIFO. Channels are fully independent; a full channel stalls only words addressed to it.
- Full FIFO with simultaneous pop: din_ready stays 0 for that channel. There is no pop-through; the push is accepted the next cycle.
- Empty FIFO: dout<k>_ready is ignored and no underflow occurs. When empty, dout<k> holds its last value. Only reset forces it to 0.
- Push and pop on the same channel in the same cycle (not full, not empty): the count is unchanged and pointers advance by one each.
- Pointers wrap modulo DEPTH. The count is held in log2(DEPTH)+1 bits.
- Reset mid-operation: all buffered words are lost and no partial state survives.

Optional Feature:
Macro ESTIMADOR_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (16 bits, reset 0).
  - drop_cnt increments on every accepted din_sel=3 word and saturates at 16'hFFFF.
  - err_sel behaves as specified above.
- Not defined: the port and counter do not exist, and err_sel is the only drop indication.

Decomposition:
- Package estimador_demux_pkg holds:
  - NUM_CH=3
  - SEL_WIDTH=2
  - typedef sel_t (logic [1:0])
  - SEL_INVALID=2'd3
  - DATA_WIDTH default
- Sub-module estimador_demux_fifo: a single-channel synchronous FIFO with push/pop, full/empty and a head output. It uses the same async active-low reset and is instantiated three times.
- The top level contains only select decode, ready generation, the error flag and the optional counter.

Test Plan:
- Reset, then send 32'hA0000001 with sel=0 → dout0=32'hA0000001 and dout0_valid=1 one cycle later; dout1_valid=0 and dout2_valid=0.
- Hold dout1_ready=0 and send three words with sel=1 → the first two are accepted and din_ready=0 for the third. Raise dout1_ready → the third word is accepted one cycle after the first pop, and the output order is preserved.
- Channel 2 full and stalled; send a word with sel=0 → it is accepted immediately (no cross-channel blocking).
- Send 32'hDEADBEEF with sel=3 → din_ready=1, no channel becomes valid, and err_sel=1 stays set. With ESTIMADOR_DEMUX_DROP_CNT_EN defined, drop_cnt=1.
- Channel 0 holds 1 entry; push with sel=0 and pop in the same cycle → count stays 1 and the new word becomes the head.
- Fill channel 0 with 2 entries, assert ap_rst_n=0 mid-cycle → dout0_valid=0 and din_ready=0 immediately. After release, channel 0 is empty and err_sel=0.
